// File: rtl/seq_gen_1010.sv
// rtl/seq_gen_1010.sv - serial pattern transmitter with valid/ready bit stream (optional SEQ_GEN_ERR_INJ_EN)
module seq_gen_1010 #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter int               REPS_W  = 4,
    parameter int               GAP     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [REPS_W-1:0] reps,
    input  logic              bit_ready,
`ifdef SEQ_GEN_ERR_INJ_EN
    input  logic              err_inj,
`endif
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              done
);

    localparam int IDX_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [REPS_W-1:0] reps_left, reps_left_n;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_n;
    logic              bit_out_n, bit_valid_n, busy_n, done_n;
    logic              err_pend;
    logic              err_flag_n;

`ifdef SEQ_GEN_ERR_INJ_EN
    logic err_flag;
    // An injection request is only honoured while a burst is running.
    assign err_pend = err_flag | (err_inj & busy);
`else
    assign err_pend = 1'b0;
`endif

    // Next-state, counters and next registered outputs.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        reps_left_n = reps_left;
        gap_cnt_n   = gap_cnt;
        err_flag_n  = err_pend;
        bit_out_n   = 1'b0;
        bit_valid_n = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start && (reps != '0)) begin
                    state_n     = S_SEND;
                    reps_left_n = reps;
                    idx_n       = IDX_MAX;
                end
            end
            S_SEND: begin
                if (bit_ready) begin
                    if (idx == '0) begin
                        if (reps_left > REPS_W'(1)) begin
                            reps_left_n = reps_left - REPS_W'(1);
                            if (GAP > 0) begin
                                state_n   = S_GAP;
                                gap_cnt_n = GAP_LOAD;
                            end else begin
                                idx_n = IDX_MAX;
                            end
                        end else begin
                            state_n     = S_FIN;
                            reps_left_n = '0;
                        end
                    end else begin
                        idx_n = idx - IDX_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt == '0) begin
                    state_n = S_SEND;
                    idx_n   = IDX_MAX;
                end else begin
                    gap_cnt_n = gap_cnt - GAP_W'(1);
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        case (state_n)
            S_SEND: begin
                bit_valid_n = 1'b1;
                busy_n      = 1'b1;
                if ((state == S_SEND) && !bit_ready) begin
                    // Stalled: the presented bit (possibly inverted) must not change.
                    bit_out_n = bit_out;
                end else if ((idx_n == '0) && err_pend) begin
                    bit_out_n  = ~PATTERN[0];
                    err_flag_n = 1'b0;
                end else begin
                    bit_out_n = PATTERN[idx_n];
                end
            end
            S_GAP: begin
                busy_n = 1'b1;
            end
            S_FIN: begin
                done_n = 1'b1;
            end
            default: begin
                busy_n = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any burst at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            idx       <= '0;
            reps_left <= '0;
            gap_cnt   <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SEQ_GEN_ERR_INJ_EN
            err_flag  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            reps_left <= reps_left_n;
            gap_cnt   <= gap_cnt_n;
            bit_out   <= bit_out_n;
            bit_valid <= bit_valid_n;
            busy      <= busy_n;
            done      <= done_n;
`ifdef SEQ_GEN_ERR_INJ_EN
            err_flag  <= err_flag_n;
`endif
        end
    end

endmodule

// File: tb/tb_seq_gen_1010.sv
// tb/tb_seq_gen_1010.sv - table-driven self-checking bench for seq_gen_1010
module tb_seq_gen_1010;

    logic       clk;
    logic       reset;
    logic       start, start0;
    logic [3:0] reps, reps0;
    logic       ready, ready0;
    logic       err, err0;
    logic       out, valid, busy, done;
    logic       out0, valid0, busy0, done0;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SEQ_GEN_ERR_INJ_EN
    localparam logic ERR_LSB = 1'b1;
`else
    localparam logic ERR_LSB = 1'b0;
`endif

    seq_gen_1010 #(.GAP(2)) dut (
        .clk(clk), .reset(reset), .start(start), .reps(reps), .bit_ready(ready),
`ifdef SEQ_GEN_ERR_INJ_EN
        .err_inj(err),
`endif
        .bit_out(out), .bit_valid(valid), .busy(busy), .done(done)
    );

    seq_gen_1010 #(.GAP(0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .reps(reps0), .bit_ready(ready0),
`ifdef SEQ_GEN_ERR_INJ_EN
        .err_inj(err0),
`endif
        .bit_out(out0), .bit_valid(valid0), .busy(busy0), .done(done0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;     // 0: GAP=2 instance, 1: GAP=0 instance
        logic       start;
        logic [3:0] reps;
        logic       ready;
        logic       err;
        logic [3:0] exp;     // {bit_out, bit_valid, busy, done} in this cycle
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic sel, input logic st, input logic [3:0] rp,
                                input logic rd, input logic er,
                                input logic o, input logic v, input logic b, input logic d);
        vec_t r;
        r.sel = sel; r.start = st; r.reps = rp; r.ready = rd; r.err = er;
        r.exp = {o, v, b, d};
        vq.push_back(r);
    endfunction

    // One repetition with bit_ready high: 1,0,1,lsb.
    function automatic void add_rep(input logic sel, input logic lsb, input logic er_first);
        add(sel, 1'b0, 4'd0, 1'b1, er_first, 1'b1, 1'b1, 1'b1, 1'b0);
        add(sel, 1'b0, 4'd0, 1'b1, 1'b0,     1'b0, 1'b1, 1'b1, 1'b0);
        add(sel, 1'b0, 4'd0, 1'b1, 1'b0,     1'b1, 1'b1, 1'b1, 1'b0);
        add(sel, 1'b0, 4'd0, 1'b1, 1'b0,     lsb,  1'b1, 1'b1, 1'b0);
    endfunction

    // Two gap cycles with bit_ready low to show the gap ignores the sink.
    function automatic void add_gap();
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got {out,valid,busy,done}=%b, want %b", name, idx, act, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; reps = 4'd0; ready = 1'b1; err = 1'b0;
        start0 = 1'b0; reps0 = 4'd0; ready0 = 1'b1; err0 = 1'b0;
    endtask

    // Each row: compare outputs of the cycle, then drive inputs sampled at its closing edge.
    task automatic run_table(input string name);
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            if (vq[i].sel)
                check(name, i, {out0, valid0, busy0, done0}, vq[i].exp);
            else
                check(name, i, {out, valid, busy, done}, vq[i].exp);
            idle_inputs();
            if (vq[i].sel) begin
                start0 = vq[i].start; reps0 = vq[i].reps; ready0 = vq[i].ready; err0 = vq[i].err;
            end else begin
                start = vq[i].start; reps = vq[i].reps; ready = vq[i].ready; err = vq[i].err;
            end
        end
        vq.delete();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        start = 1'b1; reps = 4'd3; start0 = 1'b1; reps0 = 4'd3;

        // Reset held low with start asserted.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset", i, {out, valid, busy, done}, 4'b0000);
            check("reset0", i, {out0, valid0, busy0, done0}, 4'b0000);
        end
        idle_inputs();
        reset = 1'b1;

        // Basic burst reps=3, GAP=2; also reps=0 start ignored first.
        add(1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rep(1'b0, 1'b0, 1'b0); add_gap();
        add_rep(1'b0, 1'b0, 1'b0); add_gap();
        add_rep(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("basic");

        // Backpressure on the 2nd bit, mid-burst start and start in FIN ignored.
        add(1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("backpressure");

        // GAP=0, reps=2: eight back-to-back bits, mid-burst start, then reps=0 start.
        add(1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add_rep(1'b1, 1'b0, 1'b0);
        add(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("gap0");

        // Mid-burst reset during the 3rd bit of reps=2.
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        run_table("prereset");
        #1 reset = 1'b0;
        #1 check("async_reset", 0, {out, valid, busy, done}, 4'b0000);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            check("async_reset", i, {out, valid, busy, done}, 4'b0000);
        end
        reset = 1'b1;
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rep(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("postreset");

        // Error injection: err in IDLE ignored, then err during rep 1 of reps=2.
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rep(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rep(1'b0, ERR_LSB, 1'b1); add_gap();
        add_rep(1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_table("err_inj");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
